// File: rtl/alu_result_checker.sv
// alu_result_checker
// Watches the Alu operand/result interface, recomputes the golden result for
// every accepted transaction and keeps saturating pass/fail/skip counts.
// The latest mismatch is captured in err_op/err_exp/err_act.
//
// Handshake: a transaction moves when in_valid && in_ready on a rising clk
// edge. in_ready is high exactly while the checker is in RUN; there is no
// other backpressure, so one transaction per cycle is accepted in RUN.
//
// Pipeline: the transfer cycle registers the fields into S1. The next cycle
// compares S1 against the golden model and registers the counters and err_*,
// so err_valid is seen two cycles after the transfer cycle.
module alu_result_checker #(
    parameter int CNT_W       = 16,
    parameter bit HALT_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    input  logic             uns,
    input  logic [31:0]      dut_out,
    input  logic             dut_cmp,
    input  logic             dut_ov,
    output logic             err_valid,
    output logic [2:0]       err_op,
    output logic [33:0]      err_exp,
    output logic [33:0]      err_act,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] skip_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;

    state_t st;

    // S1 transaction registers
    logic        s1_valid;
    logic [2:0]  s1_op;
    logic [31:0] s1_a;
    logic [31:0] s1_b;
    logic        s1_uns;
    logic [31:0] s1_out;
    logic        s1_cmp;
    logic        s1_ov;

    // Golden model outputs for the S1 transaction
    logic [31:0] exp_out;
    logic        exp_cmp;
    logic        exp_ov;
    logic        op_defined;
    logic [33:0] exp_vec;
    logic [33:0] act_vec;
    logic        mismatch;

    // start only acts outside RUN; stop only acts in RUN
    logic        start_go;
    logic        transfer;

    assign in_ready = (st == RUN);
    assign state    = st;
    assign transfer = in_valid && in_ready;
    assign start_go = start && (st != RUN);

    // Golden result for the transaction sitting in S1
    always_comb begin
        exp_out    = '0;
        exp_ov     = 1'b0;
        op_defined = 1'b1;
        case (s1_op)
            OP_AND: exp_out = s1_a & s1_b;
            OP_OR:  exp_out = s1_a | s1_b;
            OP_ADD: begin
                exp_out = s1_a + s1_b;
                exp_ov  = !s1_uns && (s1_a[31] == s1_b[31]) && (exp_out[31] != s1_a[31]);
            end
            OP_NOR: exp_out = ~(s1_a | s1_b);
            OP_XOR: exp_out = s1_a ^ s1_b;
            OP_SUB: begin
                exp_out = s1_a - s1_b;
                exp_ov  = !s1_uns && (s1_a[31] != s1_b[31]) && (exp_out[31] != s1_a[31]);
            end
            default: op_defined = 1'b0;
        endcase
        exp_cmp  = (exp_out == 32'd0);
        exp_vec  = {exp_ov, exp_cmp, exp_out};
        act_vec  = {s1_ov, s1_cmp, s1_out};
        mismatch = s1_valid && op_defined && (exp_vec != act_vec);
    end

    // Control FSM: stop beats a same-cycle mismatch halt in RUN
    always_ff @(posedge clk) begin
        if (reset) begin
            st <= IDLE;
        end else begin
            case (st)
                IDLE: if (start) st <= RUN;
                RUN: begin
                    if (stop)
                        st <= IDLE;
                    else if (HALT_ON_ERR && mismatch)
                        st <= HALT;
                end
                HALT: if (start) st <= RUN;
                default: st <= IDLE;
            endcase
        end
    end

    // S1: capture the accepted transaction
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_uns   <= 1'b0;
            s1_out   <= '0;
            s1_cmp   <= 1'b0;
            s1_ov    <= 1'b0;
        end else begin
            s1_valid <= transfer;
            if (transfer) begin
                s1_op  <= op;
                s1_a   <= a;
                s1_b   <= b;
                s1_uns <= uns;
                s1_out <= dut_out;
                s1_cmp <= dut_cmp;
                s1_ov  <= dut_ov;
            end
        end
    end

    // S2: counters and mismatch capture; an effective start clears and drops S2
    always_ff @(posedge clk) begin
        if (reset || start_go) begin
            err_valid <= 1'b0;
            err_op    <= '0;
            err_exp   <= '0;
            err_act   <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            skip_cnt  <= '0;
        end else begin
            err_valid <= mismatch;
            if (s1_valid) begin
                if (!op_defined) begin
                    if (skip_cnt != '1) skip_cnt <= skip_cnt + CNT_W'(1);
                end else if (mismatch) begin
                    if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
                    err_op  <= s1_op;
                    err_exp <= exp_vec;
                    err_act <= act_vec;
                end else begin
                    if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_result_checker.sv
// tb_alu_result_checker
// Three checkers share one stimulus stream: u0 (defaults), u1 (HALT_ON_ERR=1)
// and u2 (CNT_W=2). Expected mismatches on u0 are queued by the driver and
// popped by an independent monitor whenever u0 pulses err_valid.
module tb_alu_result_checker;

    localparam int W = 32 + 3 + 34 + 34;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        uns = 1'b0;
    logic [31:0] dut_out = '0;
    logic        dut_cmp = 1'b0;
    logic        dut_ov = 1'b0;

    logic        rdy0, ev0, rdy1, ev1, rdy2, ev2;
    logic [2:0]  eop0, eop1, eop2;
    logic [33:0] eexp0, eact0, eexp1, eact1, eexp2, eact2;
    logic [15:0] pc0, fc0, sc0, pc1, fc1, sc1;
    logic [1:0]  pc2, fc2, sc2;
    logic [1:0]  st0, st1, st2;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [W-1:0] exp_q[$];

    // clock/reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_result_checker u0 (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .in_valid(in_valid), .in_ready(rdy0), .op(op), .a(a), .b(b), .uns(uns),
        .dut_out(dut_out), .dut_cmp(dut_cmp), .dut_ov(dut_ov),
        .err_valid(ev0), .err_op(eop0), .err_exp(eexp0), .err_act(eact0),
        .pass_cnt(pc0), .fail_cnt(fc0), .skip_cnt(sc0), .state(st0)
    );

    alu_result_checker #(.CNT_W(16), .HALT_ON_ERR(1'b1)) u1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .in_valid(in_valid), .in_ready(rdy1), .op(op), .a(a), .b(b), .uns(uns),
        .dut_out(dut_out), .dut_cmp(dut_cmp), .dut_ov(dut_ov),
        .err_valid(ev1), .err_op(eop1), .err_exp(eexp1), .err_act(eact1),
        .pass_cnt(pc1), .fail_cnt(fc1), .skip_cnt(sc1), .state(st1)
    );

    alu_result_checker #(.CNT_W(2), .HALT_ON_ERR(1'b0)) u2 (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .in_valid(in_valid), .in_ready(rdy2), .op(op), .a(a), .b(b), .uns(uns),
        .dut_out(dut_out), .dut_cmp(dut_cmp), .dut_ov(dut_ov),
        .err_valid(ev2), .err_op(eop2), .err_exp(eexp2), .err_act(eact2),
        .pass_cnt(pc2), .fail_cnt(fc2), .skip_cnt(sc2), .state(st2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic send(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        input logic u, input logic [31:0] dout, input logic dc, input logic dov,
                        input logic bad, input logic [33:0] e);
        @(negedge clk);
        op = o; a = aa; b = bb; uns = u;
        dut_out = dout; dut_cmp = dc; dut_ov = dov;
        in_valid = 1'b1;
        if (bad) exp_q.push_back({32'(cyc + 2), o, e, {dov, dc, dout}});
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic pulse(input logic s, input logic p);
        @(negedge clk);
        start = s; stop = p;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic begin_test;
        pulse(1'b0, 1'b1);
        repeat (3) @(negedge clk);
        pulse(1'b1, 1'b0);
    endtask

    // scoreboard monitor for u0 mismatch reports
    always @(negedge clk) begin
        if (ev0) begin
            logic [W-1:0] ent;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL err_unexpected: got op=%0h exp=%0h act=%0h required no err_valid",
                         eop0, eexp0, eact0);
            end else begin
                ent = exp_q.pop_front();
                if (ent[W-1 -: 32] != 32'(cyc) || ent[70:68] !== eop0 ||
                    ent[67:34] !== eexp0 || ent[33:0] !== eact0) begin
                    fails++;
                    $display("FAIL err_record: got cyc=%0d op=%0h exp=%0h act=%0h required cyc=%0d op=%0h exp=%0h act=%0h",
                             cyc, eop0, eexp0, eact0, ent[W-1 -: 32], ent[70:68], ent[67:34], ent[33:0]);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_state", st0, 2'b00);
        check("reset_ready", rdy0, 1'b0);
        check("reset_errv", ev0, 1'b0);
        check("reset_errexp", eexp0, 34'h0);
        check("reset_cnts", {pc0, fc0, sc0}, 48'h0);

        begin_test;
        check("run_state", st0, 2'b01);
        check("run_ready", rdy0, 1'b1);

        // T1
        send(3'b000, 32'h1, 32'h1, 1'b0, 32'h1, 1'b0, 1'b0, 1'b0, 34'h0);
        idle(3);
        check("t1_pass", pc0, 16'd1);
        check("t1_fail", fc0, 16'd0);

        // T2: signed ADD overflow, then the same with ov dropped
        send(3'b010, 32'h80000001, 32'h80000001, 1'b0, 32'h2, 1'b0, 1'b1, 1'b0, 34'h0);
        send(3'b010, 32'h80000001, 32'h80000001, 1'b0, 32'h2, 1'b0, 1'b0, 1'b1, 34'h2_00000002);
        idle(3);
        check("t2_pass", pc0, 16'd2);
        check("t2_fail", fc0, 16'd1);
        check("t2_errexp", eexp0, 34'h2_00000002);
        check("t2_erract", eact0, 34'h0_00000002);

        // T3 plus a back-to-back mix of ops
        send(3'b110, 32'h80000001, 32'h7FFFFFFF, 1'b0, 32'h2, 1'b0, 1'b1, 1'b0, 34'h0);
        send(3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 34'h0);
        send(3'b001, 32'hF0F00000, 32'h00000F0F, 1'b0, 32'hF0F00F0F, 1'b0, 1'b0, 1'b0, 34'h0);
        send(3'b101, 32'h5, 32'h5, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 34'h1_00000000);
        send(3'b010, 32'hFFFFFFFF, 32'h1, 1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 34'h1_00000000);
        send(3'b010, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 34'h0);
        idle(3);
        check("t3_pass", pc0, 16'd6);
        check("t3_fail", fc0, 16'd3);

        // T5: undefined ops only bump skip_cnt
        send(3'b011, 32'h1, 32'h2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 34'h0);
        send(3'b111, 32'h3, 32'h4, 1'b0, 32'h9, 1'b1, 1'b1, 1'b0, 34'h0);
        send(3'b011, 32'h0, 32'h0, 1'b1, 32'h5, 1'b0, 1'b1, 1'b0, 34'h0);
        idle(3);
        check("t5_skip", sc0, 16'd3);
        check("t5_pass", pc0, 16'd6);
        check("t5_fail", fc0, 16'd3);

        // stop right after a transfer: in-flight result still counted
        send(3'b000, 32'hFF, 32'h0F, 1'b0, 32'h0F, 1'b0, 1'b0, 1'b0, 34'h0);
        @(negedge clk);
        in_valid = 1'b0; stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        idle(2);
        check("stop_state", st0, 2'b00);
        check("stop_ready", rdy0, 1'b0);
        check("stop_pass", pc0, 16'd7);

        // start+stop in IDLE: start wins and clears
        pulse(1'b1, 1'b1);
        check("both_idle_state", st0, 2'b01);
        check("both_idle_clr", pc0, 16'd0);
        send(3'b000, 32'h1, 32'h1, 1'b0, 32'h1, 1'b0, 1'b0, 1'b0, 34'h0);
        idle(3);
        // start+stop in RUN: stop wins, start does not clear
        pulse(1'b1, 1'b1);
        check("both_run_state", st0, 2'b00);
        check("both_run_pass", pc0, 16'd1);

        // T4: halt on first mismatch, in-flight transaction completes
        begin_test;
        check("t4_u1_run", st1, 2'b01);
        send(3'b100, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 34'h0_FFFFFFFF);
        send(3'b101, 32'h1, 32'h0, 1'b0, 32'h1, 1'b0, 1'b0, 1'b0, 34'h0);
        idle(3);
        check("t4_state", st1, 2'b10);
        check("t4_fail", fc1, 16'd1);
        check("t4_pass", pc1, 16'd1);
        check("t4_ready", rdy1, 1'b0);
        check("t4_u0_state", st0, 2'b01);
        send(3'b000, 32'h3, 32'h1, 1'b0, 32'h1, 1'b0, 1'b0, 1'b0, 34'h0);
        idle(3);
        check("t4_halt_hold", pc1, 16'd1);
        check("t4_u0_pass", pc0, 16'd2);
        pulse(1'b1, 1'b0);
        check("t4_restart", st1, 2'b01);
        check("t4_clr", {pc1, fc1, sc1}, 48'h0);
        check("t4_u0_ignore", pc0, 16'd2);

        // T5b: 2-bit counters saturate
        begin_test;
        for (int i = 0; i < 5; i++)
            send(3'b000, 32'(i), 32'hFFFFFFFF, 1'b0, 32'(i), (i == 0), 1'b0, 1'b0, 34'h0);
        idle(3);
        check("t5_sat", pc2, 2'd3);
        check("t5_u0_pass", pc0, 16'd5);

        // T6: reset the cycle after a (mismatching) transfer
        send(3'b010, 32'h1, 32'h1, 1'b0, 32'h7, 1'b0, 1'b0, 1'b0, 34'h0);
        @(negedge clk);
        in_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_state", st0, 2'b00);
        check("t6_cnts", {pc0, fc0, sc0}, 48'h0);
        check("t6_errexp", eexp0, 34'h0);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
